jump_table_loader: RTL and testbench



---
 rtl/jtl_pkg.sv | 23 ++
 rtl/jtl_match.sv | 31 +++
 rtl/jump_table_loader.sv | 142 ++++++++++++++
 tb/tb_jump_table_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtl_pkg.sv
// Shared definitions for the jump-table loader.
//   - jtl_state_e : loader FSM states (idle / clear sweep)
//   - JTL_D, JTL_N: default PC width and table depth
//   - jtl_entry_t : one table entry {valid, addr, offset}
// Optional feature macro used by the loader: JTL_DUP_CHECK_EN.
package jtl_pkg;

  localparam int JTL_D = 12;
  localparam int JTL_N = 16;

  typedef enum logic {
    JTL_IDLE  = 1'b0,
    JTL_CLEAR = 1'b1
  } jtl_state_e;

  // Entry fields are sized by JTL_D; the loader's D parameter must match it.
  typedef struct packed {
    logic              valid;
    logic [JTL_D-1:0]  addr;
    logic [JTL_D-1:0]  offset;
  } jtl_entry_t;

endpackage

// File: rtl/jtl_match.sv
// N-way address comparator with lowest-index priority encoder.
// Ports:
//   valid : per-entry valid bits
//   addrs : per-entry stored addresses
//   key   : address to search for
//   hit   : some valid entry holds key
//   idx   : lowest index of a matching valid entry (0 when no hit)
module jtl_match #(
  parameter int D = 12,
  parameter int N = 16
) (
  input  logic [N-1:0]         valid,
  input  logic [N-1:0][D-1:0]  addrs,
  input  logic [D-1:0]         key,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i] && (addrs[i] == key)) begin
        hit = 1'b1;
        idx = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/jump_table_loader.sv
// Runtime writer and lookup port for the fetch stage's jump-target table.
// Entries {branch address, signed offset} are appended over a valid/ready
// write port; a clear pulse starts a sweep that invalidates one entry per
// cycle. The lookup port combinationally forms the next PC.
//
// Handshake: a write transfers on a rising clk edge where wr_valid and
// wr_ready are both high; wr_ready never depends on wr_valid.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   clear                 : pulse, starts a clear sweep (wins over a write)
//   wr_valid/wr_ready     : write handshake
//   wr_addr/wr_offset     : entry to store
//   busy                  : clear sweep in progress
//   full, count           : occupancy
//   overflow              : sticky, write refused because table is full
//   lk_addr, lk_jump      : current PC, branch-taken
//   lk_hit, lk_target     : lookup result and next PC
//   dbg_state             : FSM state for observation
//
// Macro JTL_DUP_CHECK_EN: when defined, a write whose address is already in
// the table overwrites that entry's offset instead of appending.
module jump_table_loader
  import jtl_pkg::*;
#(
  parameter int D  = JTL_D,
  parameter int N  = JTL_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [D-1:0]  wr_addr,
  input  logic [D-1:0]  wr_offset,
  output logic          busy,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic [D-1:0]  lk_addr,
  input  logic          lk_jump,
  output logic          lk_hit,
  output logic [D-1:0]  lk_target,
  output jtl_state_e    dbg_state
);

  localparam int IW = $clog2(N);

  jtl_state_e          state;
  jtl_entry_t          tbl [N];
  logic [IW-1:0]       clr_idx;

  logic [N-1:0]        valid_vec;
  logic [N-1:0][D-1:0] addr_vec;

  logic                wr_match;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       lk_idx;

  always_comb begin
    valid_vec = '0;
    addr_vec  = '0;
    for (int i = 0; i < N; i++) begin
      valid_vec[i] = tbl[i].valid;
      addr_vec[i]  = tbl[i].addr;
    end
  end

`ifdef JTL_DUP_CHECK_EN
  jtl_match #(.D(D), .N(N)) u_wr_match (
    .valid (valid_vec),
    .addrs (addr_vec),
    .key   (wr_addr),
    .hit   (wr_match),
    .idx   (wr_idx)
  );
`else
  // Without duplicate checking every accepted write appends.
  assign wr_match = 1'b0;
  assign wr_idx   = '0;
`endif

  jtl_match #(.D(D), .N(N)) u_lk_match (
    .valid (valid_vec),
    .addrs (addr_vec),
    .key   (lk_addr),
    .hit   (lk_hit),
    .idx   (lk_idx)
  );

  assign full      = (count == CW'(N));
  assign busy      = (state == JTL_CLEAR);
  assign dbg_state = state;
  assign wr_ready  = (state == JTL_IDLE) && !clear && (!full || wr_match);

  // Modulo-2^D arithmetic: the sum simply wraps at D bits.
  assign lk_target = (lk_jump && lk_hit) ? (lk_addr + tbl[lk_idx].offset)
                                         : (lk_addr + D'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= JTL_IDLE;
      count    <= '0;
      overflow <= 1'b0;
      clr_idx  <= '0;
      for (int i = 0; i < N; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else begin
      case (state)
        JTL_IDLE: begin
          if (clear) begin
            state   <= JTL_CLEAR;
            clr_idx <= '0;
          end else if (wr_valid && wr_ready) begin
            if (wr_match) begin
              tbl[wr_idx].offset <= wr_offset;
            end else begin
              tbl[count[IW-1:0]] <= '{valid: 1'b1, addr: wr_addr, offset: wr_offset};
              count              <= count + CW'(1);
            end
          end else if (wr_valid) begin
            // In IDLE without clear, a refused write means full and no match.
            overflow <= 1'b1;
          end
        end
        JTL_CLEAR: begin
          tbl[clr_idx].valid <= 1'b0;
          clr_idx            <= clr_idx + IW'(1);
          if (clr_idx == IW'(N - 1)) begin
            state    <= JTL_IDLE;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= JTL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_table_loader.sv
module tb_jump_table_loader;
  import jtl_pkg::*;

  localparam int D  = 12;
  localparam int N  = 16;
  localparam int CW = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n   = 1'b0;
  logic          clear     = 1'b0;
  logic          wr_valid  = 1'b0;
  logic          wr_ready;
  logic [D-1:0]  wr_addr   = '0;
  logic [D-1:0]  wr_offset = '0;
  logic          busy;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [D-1:0]  lk_addr   = '0;
  logic          lk_jump   = 1'b0;
  logic          lk_hit;
  logic [D-1:0]  lk_target;
  jtl_state_e    dbg_state;

  jump_table_loader #(.D(D), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_offset (wr_offset),
    .busy      (busy),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .lk_addr   (lk_addr),
    .lk_jump   (lk_jump),
    .lk_hit    (lk_hit),
    .lk_target (lk_target),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [D-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [D-1:0] a, input logic j);
    lk_addr = a;
    lk_jump = j;
    #1;
  endtask

  task automatic do_write(input logic [D-1:0] a, input logic [D-1:0] o, input logic exp_ready);
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_offset = o;
    #1;
    check("wr_ready_at_write", {31'd0, wr_ready}, {31'd0, exp_ready});
    step();
    wr_valid = 1'b0;
  endtask

  // ---------------- lookup vector table ----------------
  typedef struct {
    logic [D-1:0] addr;
    logic         jump;
    logic         exp_hit;
    logic [D-1:0] exp_target;
  } lk_vec_t;

  lk_vec_t vecs [6];

  int exp_count;
  int n;

  initial begin
    vecs[0] = '{12'h004, 1'b1, 1'b1, 12'hFFF};
    vecs[1] = '{12'h004, 1'b0, 1'b1, 12'h005};
`ifdef JTL_DUP_CHECK_EN
    vecs[2] = '{12'h010, 1'b1, 1'b1, 12'h010};
`else
    vecs[2] = '{12'h010, 1'b1, 1'b1, 12'h024};
`endif
    vecs[3] = '{12'h011, 1'b1, 1'b0, 12'h012};
    vecs[4] = '{12'hFFF, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{12'hFFF, 1'b1, 1'b0, 12'h000};

    // Reset
    repeat (2) step();
    reset_n = 1'b1;
    lookup(12'h004, 1'b1);
    check("rst_lk_hit", {31'd0, lk_hit}, 32'd0);
    check("rst_lk_target", {20'd0, lk_target}, 32'h005);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // First write, visible next cycle, wrap on negative offset
    do_write(12'h004, 12'hFFB, 1'b1);
    lookup(12'h004, 1'b1);
    check("wrap_target", {20'd0, lk_target}, 32'hFFF);
    lookup(12'h004, 1'b0);
    check("nojump_target", {20'd0, lk_target}, 32'h005);

    // No same-cycle bypass: before the accepting edge the lookup misses
    wr_valid = 1'b1; wr_addr = 12'h010; wr_offset = 12'h014;
    lookup(12'h010, 1'b1);
    check("no_bypass_hit", {31'd0, lk_hit}, 32'd0);
    check("no_bypass_target", {20'd0, lk_target}, 32'h011);
    step();
    wr_valid = 1'b0;
    check("count_after_2", {27'd0, count}, 32'd2);
    do_write(12'h010, 12'h000, 1'b1);
`ifdef JTL_DUP_CHECK_EN
    exp_count = 2;
`else
    exp_count = 3;
`endif
    check("dup_count", {27'd0, count}, exp_count);

    // Table-driven lookups
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_target);
      lookup(vecs[i].addr, vecs[i].jump);
      check($sformatf("vec%0d_hit", i), {31'd0, lk_hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_target", i), {20'd0, lk_target}, {20'd0, exp_q.pop_front()});
    end

    // Fill to capacity with distinct addresses
    for (int i = exp_count; i < N; i++) begin
      do_write(12'h100 + 12'(i), 12'(i), 1'b1);
    end
    wr_addr = 12'h200;
    #1;
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_count", {27'd0, count}, 32'd16);
    check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    lookup(12'h10F, 1'b1);
    check("last_entry_target", {20'd0, lk_target}, 32'h11E);

    // 17th distinct write held 3 cycles
    wr_valid = 1'b1; wr_addr = 12'h200; wr_offset = 12'h001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("ovf_wr_ready%0d", c), {31'd0, wr_ready}, 32'd0);
      step();
      check($sformatf("ovf_flag%0d", c), {31'd0, overflow}, 32'd1);
    end
    wr_valid = 1'b0;
    check("ovf_count", {27'd0, count}, 32'd16);
    lookup(12'h200, 1'b1);
    check("ovf_lk_miss", {31'd0, lk_hit}, 32'd0);

    // Write to an existing address while full
`ifdef JTL_DUP_CHECK_EN
    do_write(12'h004, 12'h002, 1'b1);
    lookup(12'h004, 1'b1);
    check("overwrite_target", {20'd0, lk_target}, 32'h006);
`else
    do_write(12'h004, 12'h002, 1'b0);
    lookup(12'h004, 1'b1);
    check("no_overwrite_target", {20'd0, lk_target}, 32'hFFF);
`endif
    check("full_count_kept", {27'd0, count}, 32'd16);

    // Clear together with a write: clear wins, sweep lasts N cycles
    clear = 1'b1; wr_valid = 1'b1; wr_addr = 12'h004; wr_offset = 12'h7FF;
    #1;
    check("clear_wr_ready", {31'd0, wr_ready}, 32'd0);
    step();
    clear = 1'b0; wr_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check($sformatf("sweep_wr_ready%0d", n), {31'd0, wr_ready}, 32'd0);
      if (n == 3) begin
        lookup(12'h004, 1'b1);
        check("sweep_lk_cleared", {31'd0, lk_hit}, 32'd0);
        lookup(12'h10F, 1'b0);
        check("sweep_lk_pending", {31'd0, lk_hit}, 32'd1);
      end
      step();
    end
    check("busy_cycles", n, 32'd16);
    check("post_clear_count", {27'd0, count}, 32'd0);
    check("post_clear_overflow", {31'd0, overflow}, 32'd0);
    check("post_clear_full", {31'd0, full}, 32'd0);
    check("post_clear_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int i = 2; i < N; i++) begin
      lookup(12'h100 + 12'(i), 1'b1);
      check($sformatf("post_clear_miss%0d", i), {31'd0, lk_hit}, 32'd0);
    end
    lookup(12'h010, 1'b1);
    check("post_clear_miss_010", {31'd0, lk_hit}, 32'd0);

    // Reset in the middle of a sweep
    do_write(12'h050, 12'h001, 1'b1);
    do_write(12'h060, 12'h002, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    check("mid_sweep_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {27'd0, count}, 32'd0);
    check("abort_wr_ready", {31'd0, wr_ready}, 32'd1);
    reset_n = 1'b1;
    lookup(12'h050, 1'b1);
    check("abort_lk_miss", {31'd0, lk_hit}, 32'd0);
    check("abort_lk_target", {20'd0, lk_target}, 32'h051);

    // Table usable again after the abort
    do_write(12'h070, 12'h010, 1'b1);
    lookup(12'h070, 1'b1);
    check("reload_target", {20'd0, lk_target}, 32'h080);
    check("reload_count", {27'd0, count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
